image_framebuffer: RTL and testbench

IMAGE_FRAMEBUFFER -- requirements
Module: image_framebuffer

---
 rtl/image_framebuffer_pkg.sv | 20 ++
 rtl/fb_dpram.sv | 19 +
 rtl/image_framebuffer.sv | 87 ++++++++
 tb/tb_image_framebuffer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/image_framebuffer_pkg.sv
// image_framebuffer_pkg: shared geometry, pixel field layout and writer FSM encodings
package image_framebuffer_pkg;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int SCALE_SHIFT = 2;
  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DONE = 2'd2
  } wstate_e;
  function automatic logic [14:0] times160(input logic [14:0] a);
    return (a << 7) + (a << 5);
  endfunction
endpackage

// File: rtl/fb_dpram.sv
// fb_dpram: two-bank simple dual-port byte RAM, address MSB selects the bank, registered read
module fb_dpram #(
  parameter int DEPTH = 19200
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [15:0] waddr_i,
  input  logic [7:0]  wdata_i,
  input  logic [15:0] raddr_i,
  output logic [7:0]  rdata_o
);
  logic [7:0] mem_q [2][DEPTH];
  logic [7:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i[15]][waddr_i[14:0]] <= wdata_i;
    rdata_q <= mem_q[raddr_i[15]][raddr_i[14:0]];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/image_framebuffer.sv
// image_framebuffer: double-buffered frame store, writer fills the back bank, display
// reads the front bank upscaled; banks swap on vsync fall only once a frame is complete
module image_framebuffer #(
  parameter int IMG_W = image_framebuffer_pkg::IMG_W,
  parameter int IMG_H = image_framebuffer_pkg::IMG_H,
  parameter int SCALE_SHIFT = image_framebuffer_pkg::SCALE_SHIFT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_valid,
  input  logic       wr_sof,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic [9:0] next_x,
  input  logic [9:0] next_y,
  input  logic       vsync,
  output logic [7:0] color_out,
  output logic       disp_bank,
  output logic       swap_pulse
);
  import image_framebuffer_pkg::*;
  localparam logic [14:0] LAST = 15'(IMG_W * IMG_H - 1);
  localparam logic [9:0] DISP_W = 10'(IMG_W << SCALE_SHIFT);
  localparam logic [9:0] DISP_H = 10'(IMG_H << SCALE_SHIFT);
  wstate_e state_q, state_d;
  logic [14:0] waddr_q, waddr_d, wa, ra, ya, xa;
  logic disp_bank_q, disp_bank_d, swap_q, swap_d, vsync_q, in_range_q;
  logic fire, we, vs_fall;
  logic [7:0] rdata;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= W_IDLE;
      waddr_q <= '0;
      disp_bank_q <= 1'b0;
      swap_q <= 1'b0;
      vsync_q <= 1'b1;
      in_range_q <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      disp_bank_q <= disp_bank_d;
      swap_q <= swap_d;
      vsync_q <= vsync;
      in_range_q <= (next_x < DISP_W) && (next_y < DISP_H);
    end
  end
  always_comb begin
    fire = wr_valid & wr_ready;
    vs_fall = vsync_q & ~vsync;
    we = fire & (wr_sof | (state_q == W_FILL));
    wa = wr_sof ? '0 : waddr_q;
    state_d = state_q;
    waddr_d = waddr_q;
    disp_bank_d = disp_bank_q;
    swap_d = 1'b0;
    if (we) begin
      waddr_d = wa + 15'd1;
      state_d = (!wr_sof && waddr_q == LAST) ? W_DONE : W_FILL;
    end
    // only a completed frame may be flipped to the front
    if (state_q == W_DONE && vs_fall) begin
      state_d = W_IDLE;
      waddr_d = '0;
      disp_bank_d = ~disp_bank_q;
      swap_d = 1'b1;
    end
  end
  assign ya = 15'(next_y >> SCALE_SHIFT);
  assign xa = 15'(next_x >> SCALE_SHIFT);
  if (IMG_W == 160) begin : g_shift
    assign ra = times160(ya) + xa;
  end else begin : g_mul
    assign ra = 15'(ya * 15'(IMG_W)) + xa;
  end
  fb_dpram #(.DEPTH(IMG_W * IMG_H)) u_ram (
    .clk     (clock),
    .we_i    (we),
    .waddr_i ({~disp_bank_q, wa}),
    .wdata_i (wr_data),
    .raddr_i ({disp_bank_q, ra}),
    .rdata_o (rdata)
  );
  assign wr_ready = state_q != W_DONE;
  assign color_out = in_range_q ? rdata : 8'h00;
  assign disp_bank = disp_bank_q;
  assign swap_pulse = swap_q;
endmodule

// File: tb/tb_image_framebuffer.sv
// tb_image_framebuffer: table-driven read checks through a scoreboard plus fill/swap sequences
module tb_image_framebuffer;
  logic clock = 1'b0, reset = 1'b1, wr_valid = 1'b0, wr_sof = 1'b0, vsync = 1'b1;
  logic [7:0] wr_data = '0;
  logic [9:0] next_x = 10'd700, next_y = '0;
  logic wr_ready, disp_bank, swap_pulse;
  logic [7:0] color_out;
  int vectors = 0, miscompares = 0;
  logic [7:0] exp_q[$];
  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] c;
  } vec_t;
  vec_t va[10];
  vec_t vb[6];
  vec_t vc[3];

  image_framebuffer dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_sof(wr_sof),
    .wr_data(wr_data), .wr_ready(wr_ready), .next_x(next_x), .next_y(next_y),
    .vsync(vsync), .color_out(color_out), .disp_bank(disp_bank), .swap_pulse(swap_pulse)
  );

  always #20 clock = ~clock;

  initial begin
    #10ms;
    $display("FAIL watchdog: time limit reached, vectors %0d", vectors);
    $fatal(1);
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic stream(input int n, input int start, input bit sof);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_sof = sof && (i == 0);
      wr_data = 8'(start + i);
      step();
    end
    wr_valid = 1'b0;
    wr_sof = 1'b0;
  endtask

  task automatic vfall(input string nm, input logic swap_exp, input logic bank_exp);
    vsync = 1'b0;
    step();
    chk({nm, "_swap"}, {15'd0, swap_pulse}, {15'd0, swap_exp});
    chk({nm, "_bank"}, {15'd0, disp_bank}, {15'd0, bank_exp});
    vsync = 1'b1;
    step();
    chk({nm, "_swap_off"}, {15'd0, swap_pulse}, 16'd0);
  endtask

  task automatic rd(input string nm, input logic [9:0] x, input logic [9:0] y, input logic [7:0] c);
    logic [7:0] e;
    next_x = x;
    next_y = y;
    exp_q.push_back(c);
    step();
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("%s(%0d,%0d)", nm, x, y), {8'd0, color_out}, {8'd0, e});
    end
  endtask

  initial begin
    va = '{
      '{10'd4, 10'd4, 8'hA1}, '{10'd7, 10'd7, 8'hA1}, '{10'd0, 10'd0, 8'h00},
      '{10'd639, 10'd479, 8'hFF}, '{10'd700, 10'd0, 8'h00}, '{10'd0, 10'd480, 8'h00},
      '{10'd100, 10'd50, 8'h99}, '{10'd320, 10'd240, 8'hD0}, '{10'd1023, 10'd1023, 8'h00},
      '{10'd640, 10'd479, 8'h00}
    };
    vb = '{
      '{10'd0, 10'd0, 8'h3C}, '{10'd4, 10'd0, 8'h01}, '{10'd8, 10'd0, 8'h02},
      '{10'd400, 10'd0, 8'h64}, '{10'd639, 10'd479, 8'hFF}, '{10'd3, 10'd3, 8'h3C}
    };
    vc = '{'{10'd0, 10'd0, 8'h07}, '{10'd4, 10'd4, 8'hA8}, '{10'd700, 10'd4, 8'h00}};
    repeat (3) step();
    chk("rst_color", {8'd0, color_out}, 16'd0);
    chk("rst_bank", {15'd0, disp_bank}, 16'd0);
    chk("rst_swap", {15'd0, swap_pulse}, 16'd0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", {15'd0, wr_ready}, 16'd1);
    chk("post_rst_color", {8'd0, color_out}, 16'd0);
    vfall("idle_vfall", 1'b0, 1'b0);
    stream(4, 8'hEE, 1'b0);
    stream(19199, 0, 1'b1);
    chk("fill_19199_ready", {15'd0, wr_ready}, 16'd1);
    stream(1, 19199, 1'b0);
    chk("fill_done_ready", {15'd0, wr_ready}, 16'd0);
    stream(2, 8'hEE, 1'b0);
    chk("done_hold_ready", {15'd0, wr_ready}, 16'd0);
    vfall("frame1", 1'b1, 1'b1);
    chk("after_swap_ready", {15'd0, wr_ready}, 16'd1);
    foreach (va[i]) rd("rd_a", va[i].x, va[i].y, va[i].c);
    stream(100, 8'h55, 1'b1);
    vfall("partial", 1'b0, 1'b1);
    rd("rd_keep", 10'd4, 10'd4, 8'hA1);
    stream(50, 8'h55, 1'b0);
    stream(1, 8'h3C, 1'b1);
    stream(19198, 1, 1'b0);
    chk("restart_19199_ready", {15'd0, wr_ready}, 16'd1);
    stream(1, 19199, 1'b0);
    chk("restart_done_ready", {15'd0, wr_ready}, 16'd0);
    vfall("frame2", 1'b1, 1'b0);
    foreach (vb[i]) rd("rd_b", vb[i].x, vb[i].y, vb[i].c);
    stream(5000, 8'h11, 1'b1);
    next_x = 10'd700;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("midrst_ready", {15'd0, wr_ready}, 16'd1);
    chk("midrst_bank", {15'd0, disp_bank}, 16'd0);
    chk("midrst_color", {8'd0, color_out}, 16'd0);
    stream(10, 8'hEE, 1'b0);
    stream(19199, 7, 1'b1);
    chk("frame3_19199_ready", {15'd0, wr_ready}, 16'd1);
    stream(1, 7 + 19199, 1'b0);
    chk("frame3_done_ready", {15'd0, wr_ready}, 16'd0);
    vfall("frame3", 1'b1, 1'b1);
    foreach (vc[i]) rd("rd_c", vc[i].x, vc[i].y, vc[i].c);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
